// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch port: request/address out, ready/data back.
// The fetch unit is the master; the memory model or bus adapter is the slave.
interface pc_fetch_unit_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemReady,
        input  IMemData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemReady,
        output IMemData
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC holder and fetch/execute sequencer for the single-cycle core.
// Fetches one word per instruction, presents it for execution, commits NextPC.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          BCNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    pc_fetch_unit_if.master     imem,
    input  logic signed [31:0]  NextPC,
    input  logic                PCSrc,
    input  logic                Stall,
    input  logic                Halt,
    output logic [31:0]         Instr,
    output logic                InstrValid,
    output logic signed [31:0]  PC,
    output logic signed [31:0]  PCPlus1,
    output logic                Halted,
    output logic [31:0]         InstrCount,
    output logic [BCNT_W-1:0]   BranchCount
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [BCNT_W-1:0] BCNT_MAX = {BCNT_W{1'b1}};

    state_t              state_q, state_d;
    logic signed [31:0]  pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [31:0]         icnt_q, icnt_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                imem_req_q, imem_req_d;
    logic                instr_valid_q, instr_valid_d;
    logic                halted_q, halted_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        icnt_d  = icnt_q;
        bcnt_d  = bcnt_q;

        unique case (state_q)
            S_FETCH: begin
                if (imem.IMemReady) begin
                    instr_d = imem.IMemData;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Halt outranks Stall: a stalled halt still retires and stops the core.
                if (Halt) begin
                    icnt_d  = icnt_q + 32'd1;
                    state_d = S_HALT;
                end else if (!Stall) begin
                    pc_d   = NextPC;
                    icnt_d = icnt_q + 32'd1;
                    if (PCSrc && (bcnt_q != BCNT_MAX)) begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Status outputs are registered from the next state so they line up with it.
        imem_req_d    = (state_d == S_FETCH);
        instr_valid_d = (state_d == S_EXEC);
        halted_d      = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            icnt_q        <= 32'd0;
            bcnt_q        <= '0;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            icnt_q        <= icnt_d;
            bcnt_q        <= bcnt_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign imem.IMemReq  = imem_req_q;
    assign imem.IMemAddr = pc_q;

    assign Instr       = instr_q;
    assign InstrValid  = instr_valid_q;
    assign PC          = pc_q;
    assign PCPlus1     = pc_q + 32'sd1;
    assign Halted      = halted_q;
    assign InstrCount  = icnt_q;
    assign BranchCount = bcnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: the driver predicts each cycle's outputs
// with an instruction-level model and queues them; a monitor pops and compares.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'd0;
    localparam int          BW     = 4;
    localparam int          BMAX   = (1 << BW) - 1;

    localparam int M_FETCH = 0;
    localparam int M_EXEC  = 1;
    localparam int M_HALT  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_unit_if imem_if ();

    logic signed [31:0] next_pc;
    logic               pc_src, stall, halt;
    logic [31:0]        instr;
    logic               instr_valid;
    logic signed [31:0] pc, pc_plus1;
    logic               halted;
    logic [31:0]        instr_count;
    logic [BW-1:0]      branch_count;

    pc_fetch_unit #(.RESET_PC(RST_PC), .BCNT_W(BW)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem_if),
        .NextPC      (next_pc),
        .PCSrc       (pc_src),
        .Stall       (stall),
        .Halt        (halt),
        .Instr       (instr),
        .InstrValid  (instr_valid),
        .PC          (pc),
        .PCPlus1     (pc_plus1),
        .Halted      (halted),
        .InstrCount  (instr_count),
        .BranchCount (branch_count)
    );

    typedef struct {
        logic          req;
        logic [31:0]   addr;
        logic [31:0]   instr;
        logic          valid;
        logic [31:0]   pc;
        logic [31:0]   pcp1;
        logic          halted;
        logic [31:0]   icnt;
        logic [31:0]   bcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Instruction-level reference: what the core is doing and its architectural state.
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_icnt;
    int          m_bcnt;

    function automatic exp_t model_out();
        exp_t e;
        e.req    = (m_mode == M_FETCH);
        e.addr   = m_pc;
        e.instr  = m_instr;
        e.valid  = (m_mode == M_EXEC);
        e.pc     = m_pc;
        e.pcp1   = m_pc + 32'd1;
        e.halted = (m_mode == M_HALT);
        e.icnt   = m_icnt;
        e.bcnt   = 32'(m_bcnt);
        return e;
    endfunction

    task automatic model_reset();
        m_mode  = M_FETCH;
        m_pc    = RST_PC;
        m_instr = 32'd0;
        m_icnt  = 32'd0;
        m_bcnt  = 0;
    endtask

    task automatic model_edge(input logic rdy, input logic [31:0] dat, input logic stl,
                              input logic hlt, input logic src, input logic [31:0] npc);
        if (m_mode == M_FETCH) begin
            if (rdy) begin
                m_instr = dat;
                m_mode  = M_EXEC;
            end
        end else if (m_mode == M_EXEC) begin
            if (hlt) begin
                m_icnt = m_icnt + 32'd1;
                m_mode = M_HALT;
            end else if (!stl) begin
                m_pc   = npc;
                m_icnt = m_icnt + 32'd1;
                if (src && m_bcnt < BMAX) m_bcnt = m_bcnt + 1;
                m_mode = M_FETCH;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    endtask

    // One clock cycle of stimulus; the expected post-edge outputs are queued.
    task automatic step(input logic rst, input logic rdy, input logic [31:0] dat,
                        input logic stl, input logic hlt, input logic src,
                        input logic [31:0] npc);
        @(negedge clk);
        if (rst && !reset) begin
            model_reset();
            exp_q.push_back(model_out());
        end
        reset             = rst;
        imem_if.IMemReady = rdy;
        imem_if.IMemData  = dat;
        stall             = stl;
        halt              = hlt;
        pc_src            = src;
        next_pc           = npc;
        if (rst) model_reset();
        else     model_edge(rdy, dat, stl, hlt, src, npc);
        exp_q.push_back(model_out());
    endtask

    task automatic do_fetch(input logic rdy, input logic [31:0] dat);
        step(1'b0, rdy, dat, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    endtask

    task automatic do_exec(input logic stl, input logic hlt, input logic src,
                           input logic [31:0] npc);
        step(1'b0, 1'($urandom), $urandom, stl, hlt, src, npc);
    endtask

    // Reset pulse between edges, then a fetch response arriving after release.
    task automatic async_reset_pulse(input logic rdy, input logic [31:0] dat);
        @(negedge clk);
        #2;
        model_reset();
        exp_q.push_back(model_out());
        reset = 1'b1;
        #2;
        reset             = 1'b0;
        imem_if.IMemReady = rdy;
        imem_if.IMemData  = dat;
        model_edge(rdy, dat, 1'b0, 1'b0, 1'b0, 32'd0);
        exp_q.push_back(model_out());
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("t=%0t req=%b addr=%h valid=%b instr=%h pc=%h halted=%b icnt=%0d bcnt=%0d",
                         $time, imem_if.IMemReq, imem_if.IMemAddr, instr_valid, instr,
                         pc, halted, instr_count, branch_count);
                chk("IMemReq",     32'(imem_if.IMemReq), 32'(e.req));
                chk("IMemAddr",    imem_if.IMemAddr,     e.addr);
                chk("Instr",       instr,                e.instr);
                chk("InstrValid",  32'(instr_valid),     32'(e.valid));
                chk("PC",          pc,                   e.pc);
                chk("PCPlus1",     pc_plus1,             e.pcp1);
                chk("Halted",      32'(halted),          32'(e.halted));
                chk("InstrCount",  instr_count,          e.icnt);
                chk("BranchCount", 32'(branch_count),    e.bcnt);
            end
        end
    end

    initial begin
        imem_if.IMemReady = 1'b0;
        imem_if.IMemData  = 32'd0;
        next_pc = '0;
        pc_src  = 1'b0;
        stall   = 1'b0;
        halt    = 1'b0;
        model_reset();

        // Held reset, then reset asserted mid-EXEC and a straight-line run.
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        do_fetch(1'b1, $urandom);
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 1'b0, m_pc + 32'd1);

        // Memory wait at PC=5.
        do_fetch(1'b1, $urandom);
        do_exec(1'b0, 1'b0, 1'b0, 32'd5);
        for (int i = 0; i < 3; i++) do_fetch(1'b0, $urandom);
        do_fetch(1'b1, 32'hDEADBEEF);
        do_exec(1'b0, 1'b0, 1'b0, 32'd10);

        // Stall twice at PC=10, then a taken branch to 3.
        do_fetch(1'b1, $urandom);
        do_exec(1'b1, 1'b0, 1'($urandom), $urandom);
        do_exec(1'b1, 1'b0, 1'($urandom), $urandom);
        do_exec(1'b0, 1'b0, 1'b1, 32'd3);

        // Asynchronous reset while fetching at PC=9.
        do_fetch(1'b1, $urandom);
        do_exec(1'b0, 1'b0, 1'b0, 32'd9);
        do_fetch(1'b0, $urandom);
        async_reset_pulse(1'b1, 32'hA5A5_0001);

        // PC wrap and branch-counter saturation.
        do_exec(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        for (int i = 0; i < 17; i++) begin
            do_fetch(1'b1, $urandom);
            do_exec(1'b0, 1'b0, 1'b1, $urandom);
        end

        // Randomized traffic with occasional reset to leave HALT.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) < 7), $urandom,
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 29) == 0),
                 1'($urandom), $urandom);
        end

        // Halt together with Stall at PC=7, then inputs that must be ignored.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        do_fetch(1'b1, $urandom);
        do_exec(1'b0, 1'b0, 1'b0, 32'd7);
        do_fetch(1'b1, $urandom);
        do_exec(1'b1, 1'b1, 1'b1, $urandom);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
